// File: rtl/if_prefetch.sv
// Instruction fetch stage: owns the fetch PC, drives the ROM address and buffers
// {pc, inst} pairs in a small FIFO feeding decode over valid/ready.
module if_prefetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic [31:0]             inst_addr_o,
  input  logic [31:0]             inst_i,
  input  logic                    jump_en_i,
  input  logic [31:0]             jump_addr_i,
  output logic                    if_valid_o,
  input  logic                    if_ready_i,
  output logic [31:0]             if_inst_o,
  output logic [31:0]             if_pc_o,
  output logic [$clog2(DEPTH):0]  fifo_count_o
);
  localparam int              AW       = $clog2(DEPTH);
  localparam logic [AW:0]     CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [31:0]     NOP      = 32'h0000_0013;

  logic [31:0]   r_fetch_pc;
  logic [63:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;

  logic          w_empty;
  logic          w_pop;
  logic          w_push;
  logic [63:0]   w_head;

  assign w_empty    = (r_count == '0);
  assign if_valid_o = !w_empty & !jump_en_i;
  assign w_pop      = if_valid_o & if_ready_i;
  // A pop frees a slot in the same cycle, so a full FIFO can still accept a word.
  assign w_push     = !jump_en_i & ((r_count != CNT_FULL) | w_pop);
  assign w_head     = r_mem[r_rptr];

  assign inst_addr_o  = r_fetch_pc;
  assign fifo_count_o = r_count;

  always_comb begin
    if_inst_o = NOP;
    if_pc_o   = 32'h0;
    if (!w_empty) begin
      if_pc_o   = w_head[63:32];
      if_inst_o = w_head[31:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
    end else if (jump_en_i) begin
      r_fetch_pc <= {jump_addr_i[31:2], 2'b00};
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
    end else begin
      if (w_push) begin
        r_wptr     <= r_wptr + 1'b1;
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end
      if (w_pop)
        r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (!rst && w_push)
      r_mem[r_wptr] <= {r_fetch_pc, inst_i};
  end

endmodule

// File: tb/tb_if_prefetch.sv
// Bench for if_prefetch: directed vector table, hand sequences for wrap and
// reset-during-jump, then random traffic against a queue-based reference.
module tb_if_prefetch;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_addr_o;
  logic [31:0] inst_i;
  logic        jump_en_i;
  logic [31:0] jump_addr_i;
  logic        if_valid_o;
  logic        if_ready_i;
  logic [31:0] if_inst_o;
  logic [31:0] if_pc_o;
  logic [2:0]  fifo_count_o;

  if_prefetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .inst_addr_o(inst_addr_o), .inst_i(inst_i),
    .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i), .if_valid_o(if_valid_o),
    .if_ready_i(if_ready_i), .if_inst_o(if_inst_o), .if_pc_o(if_pc_o),
    .fifo_count_o(fifo_count_o)
  );

  always #5 clk = ~clk;

  // ROM contents: word i holds i+1.
  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a >> 2) + 32'd1;
  endfunction
  assign inst_i = rom(inst_addr_o);

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: a queue of delivered-but-not-consumed words and a fetch pointer.
  logic [31:0] qpc[$];
  logic [31:0] qinst[$];
  logic [31:0] mpc;

  logic        s_valid;
  logic [31:0] s_pc, s_inst, s_addr, s_cnt;

  task automatic step(input logic r, input logic j, input logic [31:0] ja, input logic rdy);
    logic        ev;
    logic        pop;
    @(negedge clk);
    rst = r; jump_en_i = j; jump_addr_i = ja; if_ready_i = rdy;
    #1;
    s_valid = if_valid_o; s_pc = if_pc_o; s_inst = if_inst_o;
    s_addr = inst_addr_o; s_cnt = 32'(fifo_count_o);
    ev = (qpc.size() != 0) && !j;
    chk("m_valid", 32'(s_valid), 32'(ev));
    chk("m_pc",    s_pc,   (qpc.size() != 0) ? qpc[0]   : 32'h0);
    chk("m_inst",  s_inst, (qpc.size() != 0) ? qinst[0] : 32'h13);
    chk("m_count", s_cnt,  32'(qpc.size()));
    chk("m_addr",  s_addr, mpc);
    @(posedge clk);
    if (r) begin
      qpc.delete(); qinst.delete(); mpc = RESET_PC;
    end else if (j) begin
      qpc.delete(); qinst.delete(); mpc = {ja[31:2], 2'b00};
    end else begin
      pop = ev && rdy;
      if (pop) begin
        void'(qpc.pop_front()); void'(qinst.pop_front());
      end
      if (qpc.size() < DEPTH) begin
        qpc.push_back(mpc); qinst.push_back(rom(mpc)); mpc = mpc + 32'd4;
      end
    end
  endtask

  typedef struct {
    logic        r, j;
    logic [31:0] ja;
    logic        rdy;
    logic        ev;
    logic [31:0] epc, einst, ecnt, eaddr;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic j, input logic [31:0] ja,
                              input logic rdy, input logic ev, input logic [31:0] epc,
                              input logic [31:0] einst, input logic [31:0] ecnt,
                              input logic [31:0] eaddr);
    vec_t v;
    v.r = r; v.j = j; v.ja = ja; v.rdy = rdy; v.ev = ev;
    v.epc = epc; v.einst = einst; v.ecnt = ecnt; v.eaddr = eaddr;
    return v;
  endfunction

  vec_t vt[$];

  initial begin
    // reset/stream
    vt.push_back(mk(1,0,0,1, 0,0,32'h13,0,0));
    vt.push_back(mk(0,0,0,1, 0,0,32'h13,0,0));
    vt.push_back(mk(0,0,0,1, 1,0,1,1,4));
    vt.push_back(mk(0,0,0,1, 1,4,2,1,8));
    // back-pressure from a fresh reset
    vt.push_back(mk(1,0,0,0, 1,8,3,1,32'hC));
    vt.push_back(mk(0,0,0,0, 0,0,32'h13,0,0));
    vt.push_back(mk(0,0,0,0, 1,0,1,1,4));
    vt.push_back(mk(0,0,0,0, 1,0,1,2,8));
    vt.push_back(mk(0,0,0,0, 1,0,1,3,32'hC));
    vt.push_back(mk(0,0,0,0, 1,0,1,4,32'h10));
    vt.push_back(mk(0,0,0,0, 1,0,1,4,32'h10));
    vt.push_back(mk(0,0,0,0, 1,0,1,4,32'h10));
    // full with simultaneous pop, then drain
    vt.push_back(mk(0,0,0,1, 1,0,1,4,32'h10));
    vt.push_back(mk(0,0,0,0, 1,4,2,4,32'h14));
    vt.push_back(mk(0,0,0,1, 1,4,2,4,32'h14));
    vt.push_back(mk(0,0,0,1, 1,8,3,4,32'h18));
    // jump flush with 3 entries queued
    vt.push_back(mk(1,0,0,0, 1,32'hC,4,4,32'h1C));
    vt.push_back(mk(0,0,0,0, 0,0,32'h13,0,0));
    vt.push_back(mk(0,0,0,0, 1,0,1,1,4));
    vt.push_back(mk(0,0,0,0, 1,0,1,2,8));
    vt.push_back(mk(0,1,32'h103,1, 0,0,1,3,32'hC));
    vt.push_back(mk(0,0,0,1, 0,0,32'h13,0,32'h100));
    vt.push_back(mk(0,0,0,1, 1,32'h100,32'h41,1,32'h104));
    vt.push_back(mk(0,0,0,1, 1,32'h104,32'h42,1,32'h108));

    rst = 1'b1; jump_en_i = 1'b0; jump_addr_i = '0; if_ready_i = 1'b1;
    @(posedge clk);
    qpc.delete(); qinst.delete(); mpc = RESET_PC;

    foreach (vt[i]) begin
      step(vt[i].r, vt[i].j, vt[i].ja, vt[i].rdy);
      chk($sformatf("v%0d_valid", i), 32'(s_valid), 32'(vt[i].ev));
      chk($sformatf("v%0d_pc", i),    s_pc,   vt[i].epc);
      chk($sformatf("v%0d_inst", i),  s_inst, vt[i].einst);
      chk($sformatf("v%0d_count", i), s_cnt,  vt[i].ecnt);
      chk($sformatf("v%0d_addr", i),  s_addr, vt[i].eaddr);
    end

    // PC wrap past the top of the address space
    step(0, 1, 32'hFFFF_FFF8, 1);
    step(0, 0, 0, 1);
    chk("wrap_gap_valid", 32'(s_valid), 32'h0);
    chk("wrap_addr", s_addr, 32'hFFFF_FFF8);
    step(0, 0, 0, 1);
    chk("wrap_pc0", s_pc, 32'hFFFF_FFF8);
    step(0, 0, 0, 1);
    chk("wrap_pc1", s_pc, 32'hFFFF_FFFC);
    step(0, 0, 0, 1);
    chk("wrap_pc2", s_pc, 32'h0000_0000);
    chk("wrap_valid", 32'(s_valid), 32'h1);

    // reset together with jump while full: reset wins
    for (int k = 0; k < 5; k++) step(0, 0, 0, 0);
    chk("full_before_rst", s_cnt, 32'd4);
    step(1, 1, 32'h200, 0);
    step(0, 0, 0, 0);
    chk("rstjmp_count", s_cnt, 32'd0);
    chk("rstjmp_addr", s_addr, RESET_PC);
    chk("rstjmp_valid", 32'(s_valid), 32'h0);

    // random traffic against the reference queue
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) == 0),
           $urandom, ($urandom_range(0, 1) == 1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
